// File: rtl/gshare_pkg.sv
// Shared types and counter helpers for the gshare branch predictor.
package gshare_pkg;

  localparam int unsigned GS_CTR_MAX = 4;
  localparam int unsigned GS_GHR_MAX = 16;

  typedef enum logic {GS_INIT, GS_READY} gs_state_e;

  typedef struct packed {
    logic [GS_GHR_MAX-1:0] ghr;
  } gshare_meta_t;

  function automatic logic [GS_CTR_MAX-1:0] gs_ctr_inc(input logic [GS_CTR_MAX-1:0] ctr,
                                                      input int unsigned bits);
    logic [GS_CTR_MAX-1:0] top;
    top = GS_CTR_MAX'((32'd1 << bits) - 32'd1);
    return (ctr >= top) ? top : ctr + GS_CTR_MAX'(1);
  endfunction

  function automatic logic [GS_CTR_MAX-1:0] gs_ctr_dec(input logic [GS_CTR_MAX-1:0] ctr);
    return (ctr == '0) ? '0 : ctr - GS_CTR_MAX'(1);
  endfunction

  function automatic logic [GS_CTR_MAX-1:0] gs_weak_nt(input int unsigned bits);
    return GS_CTR_MAX'((32'd1 << (bits - 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/gshare_bht_param_if.sv
// Predictor-facing bus: fetch read, predictions, speculative history and resolved updates.
interface gshare_bht_param_if #(
  parameter int unsigned VLEN     = 64,
  parameter int unsigned NR_LANES = 2,
  parameter int unsigned GHR_BITS = 9
);
  logic [VLEN-1:0]     vpc_i;
  logic                ready_o;
  logic [NR_LANES-1:0] pred_valid_o;
  logic [NR_LANES-1:0] pred_taken_o;
  logic [GHR_BITS-1:0] pred_ghr_o;
  logic                spec_valid_i;
  logic                spec_taken_i;
  logic                upd_valid_i;
  logic [VLEN-1:0]     upd_pc_i;
  logic                upd_taken_i;
  logic                upd_mispredict_i;
  logic [GHR_BITS-1:0] upd_ghr_i;

  modport master (
    output vpc_i, spec_valid_i, spec_taken_i, upd_valid_i, upd_pc_i, upd_taken_i,
           upd_mispredict_i, upd_ghr_i,
    input  ready_o, pred_valid_o, pred_taken_o, pred_ghr_o
  );

  modport slave (
    input  vpc_i, spec_valid_i, spec_taken_i, upd_valid_i, upd_pc_i, upd_taken_i,
           upd_mispredict_i, upd_ghr_i,
    output ready_o, pred_valid_o, pred_taken_o, pred_ghr_o
  );
endinterface

// File: rtl/gshare_ctr_bank.sv
// One lane's saturating-counter bank: async read port, read-modify-write update port, init port.
// GSHARE_BYPASS_EN: a read colliding with a same-cycle update returns the updated counter.
module gshare_ctr_bank
  import gshare_pkg::*;
#(
  parameter int unsigned NR_ROWS  = 512,
  parameter int unsigned CTR_BITS = 2,
  localparam int unsigned ROW_W   = $clog2(NR_ROWS)
) (
  input  logic                clk_i,
  input  logic                init_en_i,
  input  logic [ROW_W-1:0]    init_row_i,
  input  logic [ROW_W-1:0]    rd_row_i,
  output logic [CTR_BITS-1:0] rd_ctr_o,
  input  logic                wr_en_i,
  input  logic [ROW_W-1:0]    wr_row_i,
  input  logic                wr_taken_i
);

  logic [CTR_BITS-1:0] mem_q [NR_ROWS];
  logic [CTR_BITS-1:0] mem_d [NR_ROWS];
  logic [CTR_BITS-1:0] wr_old;
  logic [CTR_BITS-1:0] wr_new;

  always_comb begin
    wr_old = mem_q[wr_row_i];
    wr_new = wr_taken_i ? CTR_BITS'(gs_ctr_inc(GS_CTR_MAX'(wr_old), CTR_BITS))
                        : CTR_BITS'(gs_ctr_dec(GS_CTR_MAX'(wr_old)));
  end

  // The init sweep owns the array; training is ignored while it runs.
  always_comb begin
    mem_d = mem_q;
    if (init_en_i) begin
      mem_d[init_row_i] = CTR_BITS'(gs_weak_nt(CTR_BITS));
    end else if (wr_en_i) begin
      mem_d[wr_row_i] = wr_new;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd_ctr_o = mem_q[rd_row_i];
`ifdef GSHARE_BYPASS_EN
    if (wr_en_i && !init_en_i && (wr_row_i == rd_row_i)) begin
      rd_ctr_o = wr_new;
    end
`endif
  end

endmodule

// File: rtl/gshare_bht_param.sv
// Parametrised gshare predictor: per-lane counter banks indexed by PC XOR GHR, speculative
// GHR with mispredict recovery, init sweep on reset/flush. Optional macro: GSHARE_BYPASS_EN.
module gshare_bht_param
  import gshare_pkg::*;
#(
  parameter int unsigned VLEN     = 64,
  parameter int unsigned NR_LANES = 2,
  parameter int unsigned NR_ROWS  = 512,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned GHR_BITS = 9,
  parameter int unsigned OFFSET   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_bp_i,
  input  logic             debug_mode_i,
  gshare_bht_param_if.slave bp
);

  localparam int unsigned ROW_W     = $clog2(NR_ROWS);
  localparam int unsigned LOG_LANES = $clog2(NR_LANES);
  localparam int unsigned LANE_W    = (NR_LANES > 1) ? LOG_LANES : 1;

  gs_state_e                          state_q, state_d;
  logic [ROW_W-1:0]                   row_q, row_d;
  logic [GHR_BITS-1:0]                ghr_q, ghr_d;
  logic                               ready_q, ready_d;
  logic [NR_LANES-1:0]                pred_valid_q, pred_valid_d;
  logic [NR_LANES-1:0]                pred_taken_q, pred_taken_d;
  gshare_meta_t                       meta_q, meta_d;

  logic [VLEN-1:0]                    vpc, upd_pc;
  logic [ROW_W-1:0]                   rd_row, upd_row;
  logic [LANE_W-1:0]                  upd_lane;
  logic                               init_en, upd_en, in_ready;
  logic [NR_LANES-1:0][CTR_BITS-1:0]  rd_ctr;
  logic                               unused_bits;

  assign vpc      = bp.vpc_i;
  assign upd_pc   = bp.upd_pc_i;
  assign rd_row   = ROW_W'(vpc >> (OFFSET + LOG_LANES)) ^ ROW_W'(ghr_q);
  assign upd_row  = ROW_W'(upd_pc >> (OFFSET + LOG_LANES)) ^ ROW_W'(bp.upd_ghr_i);
  assign upd_lane = LANE_W'(upd_pc >> OFFSET) & LANE_W'(NR_LANES - 1);
  assign in_ready = (state_q == GS_READY) && !flush_bp_i;
  assign init_en  = (state_q == GS_INIT);
  assign upd_en   = in_ready && !debug_mode_i && bp.upd_valid_i;

  for (genvar l = 0; l < NR_LANES; l++) begin : g_lane
    gshare_ctr_bank #(
      .NR_ROWS  (NR_ROWS),
      .CTR_BITS (CTR_BITS)
    ) u_bank (
      .clk_i      (clk_i),
      .init_en_i  (init_en),
      .init_row_i (row_q),
      .rd_row_i   (rd_row),
      .rd_ctr_o   (rd_ctr[l]),
      .wr_en_i    (upd_en && (upd_lane == LANE_W'(l))),
      .wr_row_i   (upd_row),
      .wr_taken_i (bp.upd_taken_i)
    );
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ghr_d   = ghr_q;
    ready_d = ready_q;
    if (flush_bp_i) begin
      state_d = GS_INIT;
      row_d   = '0;
      ghr_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        GS_INIT: begin
          if (row_q == ROW_W'(NR_ROWS - 1)) begin
            state_d = GS_READY;
            ready_d = 1'b1;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
        default: begin
          // Recovery from a resolved mispredict overrides the speculative shift.
          if (!debug_mode_i) begin
            if (bp.upd_valid_i && bp.upd_mispredict_i) begin
              ghr_d = {bp.upd_ghr_i[GHR_BITS-2:0], bp.upd_taken_i};
            end else if (bp.spec_valid_i) begin
              ghr_d = {ghr_q[GHR_BITS-2:0], bp.spec_taken_i};
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    pred_valid_d = {NR_LANES{in_ready}};
    pred_taken_d = '0;
    for (int l = 0; l < NR_LANES; l++) begin
      pred_taken_d[l] = in_ready & rd_ctr[l][CTR_BITS-1];
    end
    meta_d     = '0;
    meta_d.ghr = GS_GHR_MAX'(ghr_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= GS_INIT;
      row_q        <= '0;
      ghr_q        <= '0;
      ready_q      <= 1'b0;
      pred_valid_q <= '0;
      pred_taken_q <= '0;
      meta_q       <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      ghr_q        <= ghr_d;
      ready_q      <= ready_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      meta_q       <= meta_d;
    end
  end

  assign bp.ready_o      = ready_q;
  assign bp.pred_valid_o = pred_valid_q;
  assign bp.pred_taken_o = pred_taken_q;
  assign bp.pred_ghr_o   = meta_q.ghr[GHR_BITS-1:0];

  assign unused_bits = ^{vpc, upd_pc, rd_ctr, meta_q.ghr};

endmodule

// File: tb/tb_gshare_bht_param.sv
// Directed bench for gshare_bht_param with default parameters (2 lanes, 512 rows, 2-bit ctrs, 9-bit GHR).
module tb_gshare_bht_param;

  logic clk = 1'b0;
  logic rst, flush, dbg;
  int   n_chk = 0;
  int   n_bad = 0;
  int   cnt;
  logic [1:0] exp_coll;

  always #5 clk = ~clk;

  gshare_bht_param_if #(.VLEN(64), .NR_LANES(2), .GHR_BITS(9)) bp ();

  gshare_bht_param #(
    .VLEN(64), .NR_LANES(2), .NR_ROWS(512), .CTR_BITS(2), .GHR_BITS(9), .OFFSET(1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_bp_i   (flush),
    .debug_mode_i (dbg),
    .bp           (bp)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [63:0] pc);
    bp.vpc_i = pc;
    step();
  endtask

  task automatic upd(input logic [63:0] pc, input logic [8:0] ghr, input logic tk, input logic mis);
    bp.upd_valid_i      = 1'b1;
    bp.upd_pc_i         = pc;
    bp.upd_ghr_i        = ghr;
    bp.upd_taken_i      = tk;
    bp.upd_mispredict_i = mis;
    step();
    bp.upd_valid_i      = 1'b0;
    bp.upd_mispredict_i = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bp.ready_o && n < 2000) begin
      n++;
      step();
    end
  endtask

  task automatic clear_bus();
    bp.spec_valid_i     = 1'b0;
    bp.spec_taken_i     = 1'b0;
    bp.upd_valid_i      = 1'b0;
    bp.upd_pc_i         = '0;
    bp.upd_taken_i      = 1'b0;
    bp.upd_mispredict_i = 1'b0;
    bp.upd_ghr_i        = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dbg = 1'b0;
    bp.vpc_i = '0;
    clear_bus();
    step();
    chk("rst_ready", bp.ready_o, 0);
    chk("rst_pvalid", bp.pred_valid_o, 0);
    chk("rst_ptaken", bp.pred_taken_o, 0);
    chk("rst_pghr", bp.pred_ghr_o, 0);
    rst = 1'b0;

    wait_ready(cnt);
    chk("init_len", cnt, 512);
    for (int i = 0; i < 6; i++) begin
      rd(64'h0 + 64'(i) * 64'h1234 + 64'(i) * 4);
      chk("init_rd", bp.pred_taken_o, 0);
    end
    chk("init_pvalid", bp.pred_valid_o, 2'b11);

    // pc 0x80 -> row 0x20, lane 0
    repeat (3) upd(64'h80, 9'h0, 1'b1, 1'b0);
    rd(64'h80);
    chk("sat_hi_taken", bp.pred_taken_o, 2'b01);
    upd(64'h80, 9'h0, 1'b0, 1'b0);
    rd(64'h80);
    chk("sat_hi_dec1", bp.pred_taken_o, 2'b01);
    upd(64'h80, 9'h0, 1'b0, 1'b0);
    rd(64'h80);
    chk("sat_hi_dec2", bp.pred_taken_o, 2'b00);
    // pc 0x82 -> same row, lane 1
    repeat (2) upd(64'h82, 9'h0, 1'b1, 1'b0);
    rd(64'h80);
    chk("lane1_taken", bp.pred_taken_o, 2'b10);
    repeat (2) upd(64'h80, 9'h0, 1'b0, 1'b0);
    upd(64'h80, 9'h0, 1'b1, 1'b0);
    rd(64'h80);
    chk("sat_lo", bp.pred_taken_o, 2'b10);

    bp.spec_valid_i = 1'b1;
    bp.spec_taken_i = 1'b1; step();
    bp.spec_taken_i = 1'b0; step();
    bp.spec_taken_i = 1'b1; step();
    bp.spec_valid_i = 1'b0;
    rd(64'h80);
    chk("spec_ghr", bp.pred_ghr_o, 9'h005);
    chk("spec_row_rd", bp.pred_taken_o, 2'b00);

    bp.spec_valid_i = 1'b1;
    bp.spec_taken_i = 1'b1;
    upd(64'h400, 9'h00F, 1'b0, 1'b1);
    bp.spec_valid_i = 1'b0;
    rd(64'h80);
    chk("recover_ghr", bp.pred_ghr_o, 9'h01E);
    chk("recover_rd", bp.pred_taken_o, 2'b00);

    dbg = 1'b1;
    bp.spec_valid_i = 1'b1;
    bp.spec_taken_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      upd(64'h80, 9'h01E, 1'b1, 1'(i % 2));
    end
    bp.spec_valid_i = 1'b0;
    dbg = 1'b0;
    rd(64'h80);
    chk("dbg_ghr", bp.pred_ghr_o, 9'h01E);
    chk("dbg_ctr", bp.pred_taken_o, 2'b00);

    // row 0x3E lane 0 holds 1; read and taken-update collide
`ifdef GSHARE_BYPASS_EN
    exp_coll = 2'b01;
`else
    exp_coll = 2'b00;
`endif
    bp.vpc_i = 64'h80;
    upd(64'h80, 9'h01E, 1'b1, 1'b0);
    chk("collide_rd", bp.pred_taken_o, exp_coll);
    rd(64'h80);
    chk("collide_after", bp.pred_taken_o, 2'b01);

    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_ready", bp.ready_o, 0);
    chk("flush_pvalid", bp.pred_valid_o, 0);
    repeat (200) step();
    flush = 1'b1; step(); flush = 1'b0;
    bp.spec_valid_i  = 1'b1;
    bp.spec_taken_i  = 1'b1;
    bp.upd_valid_i   = 1'b1;
    bp.upd_pc_i      = 64'h80;
    bp.upd_ghr_i     = 9'h0;
    bp.upd_taken_i   = 1'b1;
    bp.upd_mispredict_i = 1'b1;
    wait_ready(cnt);
    clear_bus();
    chk("reflush_len", cnt, 512);
    rd(64'h80);
    chk("reflush_ghr", bp.pred_ghr_o, 0);
    chk("reflush_ctr", bp.pred_taken_o, 2'b00);
    chk("reflush_pvalid", bp.pred_valid_o, 2'b11);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
